program_counter_stack: RTL
==========================

Name: program_counter_stack

Overview:
- Parametrised next-generation program counter for the nRisc core.
- Holds the current instruction address and computes the next one from a mode input: sequential increment, conditional relative branch, absolute jump, call, or return.
- An internal return-address stack (LIFO) supports nested calls.
- Sits between the control unit (mode, enable) and instruction memory (address); replaces the split-edge PC with a single-edge registered design.

Parameters:
- WIDTH, 8: address width in bits.
- DEPTH, 4: return-stack entries (>=1; need not be a power of two).
- RESET_VECTOR, 0: value loaded into SaidaPC on reset.

Ports:
- Clock  in  1  single system clock; all state updates on posedge.
- Reset_n  in  1  asynchronous, active-low reset.
- EscPC  in  1  PC write enable; 0 = stall (no state change).
- Modo  in  3  next-PC mode: 000 INC, 001 BRANCH, 010 JUMP, 011 CALL, 100 RET, 101-111 illegal.
- Cond  in  1  branch condition, used only in BRANCH.
- Offset  in  WIDTH  signed two's-complement branch displacement.
- Destino  in  WIDTH  absolute target for JUMP and CALL.
- SaidaPC  out  WIDTH  current PC, registered.
- PCMais1  out  WIDTH  combinational SaidaPC+1, mod 2^WIDTH.
- PilhaVazia  out  1  stack empty.
- PilhaCheia  out  1  stack full.
- Profundidade  out  clog2(DEPTH+1)  number of occupied stack entries.
- Erro  out  1  sticky error flag.

Behaviour:
- Reset (Reset_n=0, async, overrides everything):
  - SaidaPC=RESET_VECTOR, stack pointer=0, Profundidade=0, Erro=0.
  - PilhaVazia=1, PilhaCheia=0.
  - Stack contents are don't-care.
- Latency: mode and operands sampled on posedge with EscPC=1; the new SaidaPC is visible after that edge (1 cycle). PilhaVazia, PilhaCheia and Profundidade derive from the registered pointer.
- EscPC=0: SaidaPC, stack, pointer and Erro all hold; Modo is ignored, including illegal codes.
- INC: PC <= PC+1.
- BRANCH: Cond=1 -> PC <= PC+Offset (sign-extended, mod 2^WIDTH); Cond=0 -> PC <= PC+1.
- JUMP: PC <= Destino.
- CALL, stack not full: push PC+1, pointer+1, PC <= Destino.
- CALL, stack full: overflow. PC <= PC+1, stack unchanged, Erro <= 1.
- RET, stack not empty: PC <= top entry, pointer-1.
- RET, stack empty: underflow. PC <= PC+1, pointer stays 0, Erro <= 1.
- Illegal Modo (101-111): treated as INC, Erro <= 1.
- Arithmetic: all address sums wrap modulo 2^WIDTH, e.g. PC=0xFF with INC -> 0x00. Offset=0x80 means -128.
- Erro is sticky; only Reset_n clears it.
- Only one stack operation happens per cycle; no simultaneous push and pop exists by construction.
- Reset asserted mid-sequence: the stack is emptied immediately, without waiting for a clock edge.
- DEPTH=1: PilhaVazia and PilhaCheia are mutually exclusive and toggle on every successful CALL/RET.

Decomposition:
- Package pc_pkg holds:
  - Modo encodings as localparams: MODO_INC, MODO_BRANCH, MODO_JUMP, MODO_CALL, MODO_RET.
  - Width constant MODO_W=3.
- Sub-module pilha_retorno(WIDTH, DEPTH) implements the LIFO:
  - Inputs: push, pop, din.
  - Outputs: top, vazia, cheia, count.
  - Same async active-low reset.
- Top level: next-PC mux, PC register, error logic.

Test Plan (WIDTH=8, DEPTH=4, RESET_VECTOR=0x00):
- Reset then 3 cycles INC -> SaidaPC 0x00, 0x01, 0x02, 0x03; PilhaVazia=1, Erro=0.
- PC=0x10: BRANCH Cond=1 Offset=0xFC -> 0x0C. BRANCH Cond=0 -> 0x0D. JUMP Destino=0xFF, then INC -> 0xFF, then 0x00.
- Nested calls, from PC=0x20:
  - CALL 0x40 -> PC 0x40, Profundidade 1.
  - CALL 0x60 -> PC 0x60, Profundidade 2.
  - RET -> PC 0x41; RET -> PC 0x21; PilhaVazia=1, Erro=0.
- 4 CALLs fill the stack (PilhaCheia=1). A 5th CALL to 0x80 from PC=p -> PC=p+1, Profundidade stays 4, Erro=1. Four RETs still return the correct addresses.
- RET on empty stack at PC=0x30 -> PC=0x31, Erro=1. Modo=111 at PC=0x31 -> PC=0x32, Erro stays 1.
- EscPC=0 for 3 cycles with Modo=CALL -> no change to PC, Profundidade or Erro.
- Reset_n pulsed low between clock edges with Profundidade=3 -> SaidaPC=0x00, Profundidade=0, Erro=0 immediately, before the next edge.

Source files
------------

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared mode encodings for the program counter block
package pc_pkg;

    localparam int MODO_W = 3;

    localparam logic [MODO_W-1:0] MODO_INC    = 3'b000;
    localparam logic [MODO_W-1:0] MODO_BRANCH = 3'b001;
    localparam logic [MODO_W-1:0] MODO_JUMP   = 3'b010;
    localparam logic [MODO_W-1:0] MODO_CALL   = 3'b011;
    localparam logic [MODO_W-1:0] MODO_RET    = 3'b100;

endpackage

// File: rtl/pilha_retorno.sv
// rtl/pilha_retorno.sv - return-address LIFO with occupancy flags
module pilha_retorno #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       Clock,
    input  logic                       Reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           top,
    output logic                       vazia,
    output logic                       cheia,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    ptr;
    logic [CW-1:0]    ptr_m1;
    logic [IW-1:0]    wr_idx;
    logic [IW-1:0]    rd_idx;
    logic             do_push;
    logic             do_pop;

    // The pointer is the number of occupied entries; the top sits one below it.
    assign ptr_m1  = ptr - CW'(1);
    assign wr_idx  = ptr[IW-1:0];
    assign rd_idx  = ptr_m1[IW-1:0];
    assign vazia   = (ptr == '0);
    assign cheia   = (ptr == CW'(DEPTH));
    assign count   = ptr;
    assign top     = vazia ? '0 : mem[rd_idx];

    // Guard locally as well so a careless caller can never corrupt the pointer.
    assign do_push = push & ~cheia;
    assign do_pop  = pop & ~vazia & ~push;

    // Occupancy pointer: cleared asynchronously, which empties the stack at once.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            ptr <= '0;
        end else if (do_push) begin
            ptr <= ptr + CW'(1);
        end else if (do_pop) begin
            ptr <= ptr_m1;
        end
    end

    // Entry storage needs no reset; entries above the pointer are never read.
    always_ff @(posedge Clock) begin
        if (do_push) begin
            mem[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/program_counter_stack.sv
// rtl/program_counter_stack.sv - registered PC with branch/jump/call/return and error flag
module program_counter_stack
    import pc_pkg::*;
#(
    parameter int              WIDTH        = 8,
    parameter int              DEPTH        = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                       Clock,
    input  logic                       Reset_n,
    input  logic                       EscPC,
    input  logic [MODO_W-1:0]          Modo,
    input  logic                       Cond,
    input  logic [WIDTH-1:0]           Offset,
    input  logic [WIDTH-1:0]           Destino,
    output logic [WIDTH-1:0]           SaidaPC,
    output logic [WIDTH-1:0]           PCMais1,
    output logic                       PilhaVazia,
    output logic                       PilhaCheia,
    output logic [$clog2(DEPTH+1)-1:0] Profundidade,
    output logic                       Erro
);

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] stack_top;
    logic             push;
    logic             pop;
    logic             set_err;
    logic             vazia;
    logic             cheia;

    // Offset has the full address width, so plain modular addition is the signed add.
    assign pc_inc  = pc + WIDTH'(1);
    assign SaidaPC = pc;
    assign PCMais1 = pc_inc;
    assign PilhaVazia = vazia;
    assign PilhaCheia = cheia;

    pilha_retorno #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_pilha (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .push    (push),
        .pop     (pop),
        .din     (pc_inc),
        .top     (stack_top),
        .vazia   (vazia),
        .cheia   (cheia),
        .count   (Profundidade)
    );

    // Next-PC selection plus stack requests; overflow, underflow and bad modes fall back to INC.
    always_comb begin
        pc_next = pc;
        push    = 1'b0;
        pop     = 1'b0;
        set_err = 1'b0;
        if (EscPC) begin
            case (Modo)
                MODO_INC:    pc_next = pc_inc;
                MODO_BRANCH: pc_next = Cond ? (pc + Offset) : pc_inc;
                MODO_JUMP:   pc_next = Destino;
                MODO_CALL: begin
                    if (cheia) begin
                        pc_next = pc_inc;
                        set_err = 1'b1;
                    end else begin
                        pc_next = Destino;
                        push    = 1'b1;
                    end
                end
                MODO_RET: begin
                    if (vazia) begin
                        pc_next = pc_inc;
                        set_err = 1'b1;
                    end else begin
                        pc_next = stack_top;
                        pop     = 1'b1;
                    end
                end
                default: begin
                    pc_next = pc_inc;
                    set_err = 1'b1;
                end
            endcase
        end
    end

    // PC register; holds whenever EscPC is low because pc_next defaults to pc.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            pc <= RESET_VECTOR;
        end else begin
            pc <= pc_next;
        end
    end

    // Sticky error: once set only reset clears it.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Erro <= 1'b0;
        end else if (set_err) begin
            Erro <= 1'b1;
        end
    end

endmodule
